// File: rtl/shared_mem_arbiter_pkg.sv
// Shared definitions for the multi-core data-memory arbiter: FSM encodings and sizing helpers.
package shared_mem_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b001,
      ST_ACCESS = 3'b010,
      ST_DONE   = 3'b100
   } state_t;

   localparam int MAX_CORES = 8;

   // Core index width for 2..MAX_CORES requesters.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : (n <= 4) ? 2 : $clog2(MAX_CORES);
   endfunction

endpackage

// File: rtl/shared_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate eligible by prio, take the first set bit, un-rotate.
module shared_mem_arbiter_rr_pick
   import shared_mem_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  i_eligible,
   input  logic [IW-1:0] i_prio,
   output logic          o_found,
   output logic [IW-1:0] o_idx
);

   logic [N-1:0] w_rot;

   // prio is always < N, so one conditional subtract is a full modulo.
   function automatic int wrap(input int v);
      return (v >= N) ? v - N : v;
   endfunction

   always_comb begin
      w_rot   = '0;
      o_found = 1'b0;
      o_idx   = '0;
      for (int k = 0; k < N; k++) begin
         w_rot[k] = i_eligible[wrap(int'(i_prio) + k)];
      end
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            o_found = 1'b1;
            o_idx   = IW'(wrap(int'(i_prio) + k));
         end
      end
   end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between NUM_CORES cores,
// one complete access (grant, access, done, ack) per grant.
module shared_mem_arbiter
   import shared_mem_arbiter_pkg::*;
#(
   parameter int NUM_CORES  = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                             i_clk,
   input  logic                             i_reset,
   input  logic [NUM_CORES-1:0]             i_req,
   input  logic [NUM_CORES-1:0]             i_req_we,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0]  i_req_addr,
   input  logic [NUM_CORES*DATA_WIDTH-1:0]  i_req_wdata,
   output logic [NUM_CORES-1:0]             o_gnt,
   output logic [NUM_CORES-1:0]             o_ack,
   output logic [DATA_WIDTH-1:0]            o_rdata,
   output logic [ADDR_WIDTH-1:0]            o_mem_addr,
   output logic [DATA_WIDTH-1:0]            o_mem_wdata,
   output logic                             o_mem_we,
   input  logic [DATA_WIDTH-1:0]            i_mem_rdata
);

   localparam int IW = idx_w(NUM_CORES);

   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } mem_req_t;

   state_t                 r_state, w_state_nxt;
   logic                   w_illegal;
   logic [NUM_CORES-1:0]   r_gnt, r_ack;
   logic [DATA_WIDTH-1:0]  r_rdata;
   logic [IW-1:0]          r_owner, r_prio;
   mem_req_t               r_req, w_sel;
   logic [NUM_CORES-1:0]   w_eligible;
   logic                   w_found;
   logic [IW-1:0]          w_pick;

   function automatic logic [NUM_CORES-1:0] onehot(input logic [IW-1:0] idx);
      logic [NUM_CORES-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // A core acked this cycle is still holding req; it must not win again immediately.
   assign w_eligible = i_req & ~r_ack;

   shared_mem_arbiter_rr_pick #(.N(NUM_CORES), .IW(IW)) u_pick (
      .i_eligible (w_eligible),
      .i_prio     (r_prio),
      .o_found    (w_found),
      .o_idx      (w_pick)
   );

   assign w_sel.we    = i_req_we[w_pick];
   assign w_sel.addr  = i_req_addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_sel.wdata = i_req_wdata[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];

   always_ff @(posedge i_clk) begin
      if (!i_reset) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = ST_IDLE;
      w_illegal   = 1'b0;
      case (r_state)
         ST_IDLE:   w_state_nxt = w_found ? ST_ACCESS : ST_IDLE;
         ST_ACCESS: w_state_nxt = ST_DONE;
         ST_DONE:   w_state_nxt = ST_IDLE;
         default:   w_illegal   = 1'b1;
      endcase
   end

   // A corrupted state register is treated exactly like a reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset || w_illegal) begin
         r_gnt   <= '0;
         r_ack   <= '0;
         r_rdata <= '0;
         r_owner <= '0;
         r_prio  <= '0;
         r_req   <= '0;
      end else begin
         r_ack <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_owner <= w_pick;
                  r_req   <= w_sel;
                  r_gnt   <= onehot(w_pick);
               end
            end
            ST_DONE: begin
               if (!r_req.we) r_rdata <= i_mem_rdata;
               r_ack  <= onehot(r_owner);
               r_gnt  <= '0;
               r_prio <= (r_owner == IW'(NUM_CORES - 1)) ? '0 : r_owner + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_gnt       = r_gnt;
   assign o_ack       = r_ack;
   assign o_rdata     = r_rdata;
   assign o_mem_addr  = r_req.addr;
   assign o_mem_wdata = r_req.wdata;
   // Gated by reset so a reset landing mid-access never commits the write.
   assign o_mem_we    = (r_state == ST_ACCESS) && r_req.we && i_reset;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_shared_mem_arbiter;

   localparam int NC = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NC-1:0]     req, req_we;
   logic [NC*32-1:0]  req_addr, req_wdata;
   logic [NC-1:0]     gnt, ack;
   logic [31:0]       rdata, mem_addr, mem_wdata, mem_rdata;
   logic              mem_we;

   logic              pl_en;
   logic [7:0]        pl_addr;
   logic [31:0]       pl_data;
   logic [31:0]       ram [256] = '{default: 32'h0};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shared_mem_arbiter #(.NUM_CORES(NC), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .i_clk       (clk),
      .i_reset     (rst_n),
      .i_req       (req),
      .i_req_we    (req_we),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .o_gnt       (gnt),
      .o_ack       (ack),
      .o_rdata     (rdata),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .o_mem_we    (mem_we),
      .i_mem_rdata (mem_rdata)
   );

   // Synchronous RAM the DUT drives.
   always @(posedge clk) begin
      if (pl_en) ram[pl_addr] <= pl_data;
      else if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[7:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: each grant is a 2-cycle access followed by an ack cycle.
   bit          m_valid = 0;
   bit          m_busy;
   int          m_phase, m_owner, m_prio;
   logic        m_we;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [NC-1:0] m_ack;
   logic [31:0] gold [256] = '{default: 32'h0};

   initial begin
      logic [NC-1:0] prev_ack;
      int c;
      forever begin
         @(posedge clk);
         if (pl_en) gold[pl_addr] = pl_data;
         if (!rst_n) begin
            m_valid = 1; m_busy = 0; m_phase = 0; m_ack = '0; m_rdata = '0;
            m_addr = '0; m_wdata = '0; m_we = 0; m_prio = 0; m_owner = 0;
         end else begin
            prev_ack = m_ack;
            m_ack    = '0;
            if (m_busy && m_phase == 1) begin
               if (m_we) gold[m_addr[7:0]] = m_wdata;
               m_phase = 2;
            end else if (m_busy) begin
               if (!m_we) m_rdata = gold[m_addr[7:0]];
               m_ack[m_owner] = 1'b1;
               m_busy = 0;
               m_prio = (m_owner + 1) % NC;
            end else begin
               for (int k = 0; k < NC; k++) begin
                  c = (m_prio + k) % NC;
                  if (!m_busy && req[c] && !prev_ack[c]) begin
                     m_busy = 1; m_phase = 1; m_owner = c;
                     m_we = req_we[c]; m_addr = req_addr[c*32 +: 32]; m_wdata = req_wdata[c*32 +: 32];
                  end
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            chk("gnt", {28'h0, gnt}, m_busy ? (32'h1 << m_owner) : 32'h0);
            chk("ack", {28'h0, ack}, {28'h0, m_ack});
            chk("rdata", rdata, m_rdata);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_we", {31'h0, mem_we}, {31'h0, m_busy && m_phase == 1 && m_we && rst_n});
         end
      end
   end

   function automatic int oh2i(input logic [NC-1:0] v);
      int r = -1;
      for (int k = 0; k < NC; k++) if (v[k]) r = k;
      return r;
   endfunction

   task automatic set_req(input int core, input logic we, input logic [31:0] addr, input logic [31:0] wd);
      req_we[core]           = we;
      req_addr[core*32 +: 32]  = addr;
      req_wdata[core*32 +: 32] = wd;
      req[core]              = 1'b1;
   endtask

   task automatic run_access(input int core, input logic we, input logic [31:0] addr, input logic [31:0] wd);
      bit ok = 0;
      @(negedge clk);
      set_req(core, we, addr, wd);
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (ack[core]) ok = 1;
      end
      req[core] = 1'b0;
      chk("ack_seen", {31'h0, ok}, 32'h1);
   endtask

   // Collect n acks from the currently held requests, dropping everything on the last one.
   task automatic collect(input int n, input bit drop_each, output int ord [8], output int cyc [8], output int got);
      got = 0;
      for (int i = 0; i < 80 && got < n; i++) begin
         @(negedge clk);
         if (ack != '0) begin
            ord[got] = oh2i(ack);
            cyc[got] = i;
            if (drop_each) req[oh2i(ack)] = 1'b0;
            got++;
            if (got == n) req = '0;
         end
      end
   endtask

   initial begin
      int ord [8];
      int cyc [8];
      int got;
      int exp3 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int exp4 [4] = '{0, 3, 0, 3};

      req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      pl_en = 0; pl_addr = '0; pl_data = '0;
      rst_n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", {28'h0, gnt}, 32'h0);
      chk("rst_ack", {28'h0, ack}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
      pl_en = 1; pl_addr = 8'h10; pl_data = 32'hDEADBEEF;
      @(negedge clk);
      pl_addr = 8'h30; pl_data = 32'hA5A5A5A5;
      @(negedge clk);
      pl_en = 0;
      @(posedge clk); #1 rst_n = 1;

      // Single read by core 2
      @(negedge clk);
      set_req(2, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      chk("t1_gnt_T1", {28'h0, gnt}, 32'h4);
      chk("t1_mem_addr", mem_addr, 32'h10);
      @(negedge clk);
      chk("t1_gnt_T2", {28'h0, gnt}, 32'h4);
      @(negedge clk);
      chk("t1_ack", {28'h0, ack}, 32'h4);
      chk("t1_rdata", rdata, 32'hDEADBEEF);
      req[2] = 1'b0;

      // Single write by core 1, then read back by core 3
      @(negedge clk);
      set_req(1, 1'b1, 32'h20, 32'h12345678);
      @(negedge clk);
      chk("t2_we_T1", {31'h0, mem_we}, 32'h1);
      @(negedge clk);
      chk("t2_we_T2", {31'h0, mem_we}, 32'h0);
      @(negedge clk);
      chk("t2_ack", {28'h0, ack}, 32'h2);
      chk("t2_rdata_kept", rdata, 32'hDEADBEEF);
      req[1] = 1'b0;
      run_access(3, 1'b0, 32'h20, 32'h0);
      chk("t2_readback", rdata, 32'h12345678);

      // All four request together after reset
      @(posedge clk); #1 rst_n = 0;
      @(posedge clk); #1 rst_n = 1;
      @(negedge clk);
      for (int k = 0; k < NC; k++) set_req(k, 1'b0, 32'h40 + 32'(k * 4), 32'h0);
      collect(8, 1'b0, ord, cyc, got);
      chk("t3_count", got, 8);
      for (int j = 0; j < 8; j++) begin
         chk("t3_order", ord[j], exp3[j]);
         if (j > 0) chk("t3_spacing", cyc[j] - cyc[j-1], 3);
      end

      // Core 0 always requesting against held core 3
      @(negedge clk);
      set_req(0, 1'b0, 32'h50, 32'h0);
      set_req(3, 1'b0, 32'h54, 32'h0);
      collect(4, 1'b0, ord, cyc, got);
      chk("t4_count", got, 4);
      for (int j = 0; j < 4; j++) chk("t4_order", ord[j], exp4[j]);

      // Reset during the access phase of a write
      run_access(1, 1'b0, 32'h44, 32'h0);
      @(negedge clk);
      set_req(2, 1'b1, 32'h30, 32'h00000055);
      @(posedge clk); #1 rst_n = 0;
      @(negedge clk);
      chk("t5_we_blocked", {31'h0, mem_we}, 32'h0);
      req[2] = 1'b0;
      @(posedge clk); #1 rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t5_no_ack", {28'h0, ack}, 32'h0);
         chk("t5_no_gnt", {28'h0, gnt}, 32'h0);
      end
      chk("t5_mem_kept", ram[8'h30], 32'hA5A5A5A5);
      set_req(1, 1'b0, 32'h10, 32'h0);
      set_req(3, 1'b0, 32'h30, 32'h0);
      collect(2, 1'b1, ord, cyc, got);
      chk("t5_count", got, 2);
      chk("t5_prio_first", ord[0], 1);
      chk("t5_prio_second", ord[1], 3);
      chk("t5_rdata", rdata, 32'hA5A5A5A5);

      // Address change and req drop after grant
      @(negedge clk);
      set_req(1, 1'b0, 32'h10, 32'h0);
      @(posedge clk); #1;
      req_addr[1*32 +: 32] = 32'h20;
      req[1] = 1'b0;
      got = 0;
      for (int i = 0; i < 10 && got == 0; i++) begin
         @(negedge clk);
         if (ack[1]) got = 1;
      end
      chk("t6_ack", got, 1);
      chk("t6_rdata", rdata, 32'hDEADBEEF);
      chk("t6_mem_addr", mem_addr, 32'h10);

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
